// File: rtl/swm_rx_pkg.sv
// Shared constants for the SerialLite III RX width adapter: default parameters,
// error-flag width and the bit layout of a buffered beat entry.
package swm_rx_pkg;

  localparam int unsigned DEF_LANES      = 1;
  localparam int unsigned DEF_OUT_W      = 32;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  localparam int unsigned LANE_W = 64;
  localparam int unsigned ERR_W  = 6;
  localparam int unsigned CNT_W  = 16;

  // Entry layout: flags in the low bits, beat data above them.
  localparam int unsigned ENT_SOP  = 0;
  localparam int unsigned ENT_EOP  = 1;
  localparam int unsigned ENT_ERR  = 2;
  localparam int unsigned ENT_DATA = 3;

  function automatic int unsigned entry_width(input int unsigned data_w);
    return data_w + ENT_DATA;
  endfunction

endpackage

// File: rtl/swm_rx_fifo.sv
// Show-ahead FIFO with registered occupancy; o_ready is a registered not-full
// flag so the write side never depends combinationally on the read side.
module swm_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_ready,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_valid
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic             r_ready;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && r_ready;
  assign w_pop   = i_pop && (r_count != '0);
  assign o_ready = r_ready;
  assign o_valid = (r_count != '0);
  assign o_rdata = r_mem[r_rptr];

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ready <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt < CW'(DEPTH));
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/swm_rx_width_adapter.sv
// SerialLite III RX beat to Avalon-ST word adapter: buffers wide beats and
// serializes them LSB-word first, tracking per-packet and global error state.
module swm_rx_width_adapter
  import swm_rx_pkg::*;
#(
  parameter int unsigned LANES      = DEF_LANES,
  parameter int unsigned OUT_W      = DEF_OUT_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk_in_clk,
  input  logic                  reset_in_rst,
  input  logic [LANE_W*LANES-1:0] data_rx,
  input  logic                  valid_rx,
  input  logic                  start_of_burst_rx,
  input  logic                  end_of_burst_rx,
  input  logic [ERR_W-1:0]      error_rx,
  input  logic [7:0]            sync_rx,
  output logic                  ready_rx,
  output logic [OUT_W-1:0]      avalonst_source_data,
  output logic                  avalonst_source_valid,
  output logic                  avalonst_source_startofpacket,
  output logic                  avalonst_source_endofpacket,
  output logic                  avalonst_source_error,
  input  logic                  avalonst_source_ready,
  output logic [ERR_W-1:0]      err_flags,
  output logic [CNT_W-1:0]      err_count
);

  localparam int unsigned DATA_W = LANE_W * LANES;
  localparam int unsigned WORDS  = DATA_W / OUT_W;
  localparam int unsigned WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned ENT_W  = entry_width(DATA_W);

  logic              w_fifo_ready;
  logic              w_fifo_valid;
  logic              w_accept;
  logic              w_beat_err;
  logic              w_pkt_err;
  logic              w_xfer;
  logic              w_last_word;
  logic              w_pop;
  logic              w_unused_sync;
  logic [ENT_W-1:0]  w_wr_entry;
  logic [ENT_W-1:0]  w_rd_entry;
  logic [DATA_W-1:0] w_rd_data;

  logic              r_pkt_acc;
  logic [WIDX_W-1:0] r_widx;
  logic [ERR_W-1:0]  r_err_flags;
  logic [CNT_W-1:0]  r_err_count;

  assign w_unused_sync = ^sync_rx;

  assign w_accept   = valid_rx && w_fifo_ready;
  assign w_beat_err = |error_rx;
  assign w_pkt_err  = r_pkt_acc | w_beat_err;
  assign w_wr_entry = {data_rx, w_pkt_err, end_of_burst_rx, start_of_burst_rx};

  assign w_rd_data   = w_rd_entry[ENT_DATA +: DATA_W];
  assign w_last_word = (r_widx == WIDX_W'(WORDS - 1));
  assign w_xfer      = w_fifo_valid && avalonst_source_ready;
  assign w_pop       = w_xfer && w_last_word;

  swm_rx_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk_in_clk),
    .i_rst   (reset_in_rst),
    .i_push  (w_accept),
    .i_wdata (w_wr_entry),
    .o_ready (w_fifo_ready),
    .i_pop   (w_pop),
    .o_rdata (w_rd_entry),
    .o_valid (w_fifo_valid)
  );

  // Output view of the head entry; framing flags gated by valid so reset is clean.
  assign ready_rx                      = w_fifo_ready;
  assign avalonst_source_valid         = w_fifo_valid;
  assign avalonst_source_data          = w_rd_data[r_widx*OUT_W +: OUT_W];
  assign avalonst_source_startofpacket = w_fifo_valid && w_rd_entry[ENT_SOP] && (r_widx == '0);
  assign avalonst_source_endofpacket   = w_fifo_valid && w_rd_entry[ENT_EOP] && w_last_word;
  assign avalonst_source_error         = avalonst_source_endofpacket && w_rd_entry[ENT_ERR];
  assign err_flags                     = r_err_flags;
  assign err_count                     = r_err_count;

  always_ff @(posedge clk_in_clk or posedge reset_in_rst) begin
    if (reset_in_rst) begin
      r_widx <= '0;
    end else if (w_xfer) begin
      r_widx <= w_last_word ? '0 : r_widx + WIDX_W'(1);
    end
  end

  // Packet error accumulator plus sticky flags and saturating error-beat count.
  always_ff @(posedge clk_in_clk or posedge reset_in_rst) begin
    if (reset_in_rst) begin
      r_pkt_acc   <= 1'b0;
      r_err_flags <= '0;
      r_err_count <= '0;
    end else if (w_accept) begin
      r_pkt_acc   <= end_of_burst_rx ? 1'b0 : w_pkt_err;
      r_err_flags <= r_err_flags | error_rx;
      if (w_beat_err && (r_err_count != '1)) begin
        r_err_count <= r_err_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_swm_rx_width_adapter.sv
// Self-checking bench for swm_rx_width_adapter: directed scenarios plus a
// randomized stream checked against a queue-based serialization model.
module tb_swm_rx_width_adapter;

  localparam int unsigned LANES = 1;
  localparam int unsigned OUT_W = 32;
  localparam int unsigned WORDS = 64 * LANES / OUT_W;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             sop;
    logic             eop;
    logic             err;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [64*LANES-1:0] data_rx;
  logic                valid_rx;
  logic                sop_rx;
  logic                eop_rx;
  logic [5:0]          error_rx;
  logic [7:0]          sync_rx;
  logic                ready_rx;
  logic [OUT_W-1:0]    src_data;
  logic                src_valid;
  logic                src_sop;
  logic                src_eop;
  logic                src_err;
  logic                src_ready;
  logic [5:0]          err_flags;
  logic [15:0]         err_count;

  logic [127:0] b_data;
  logic         b_valid;
  logic         b_sop;
  logic         b_eop;
  logic         b_ready;
  logic [63:0]  b_out_data;
  logic         b_out_valid;
  logic         b_out_sop;
  logic         b_out_eop;
  logic         b_out_err;
  logic [5:0]   b_flags;
  logic [15:0]  b_count;

  int n_checks = 0;
  int n_errors = 0;

  word_t       exp_q[$];
  logic        m_acc = 1'b0;
  logic [5:0]  m_flags = '0;
  logic [15:0] m_count = '0;
  logic        last_eop_err = 1'b0;
  logic        rnd_done = 1'b0;

  always #5 clk = ~clk;

  swm_rx_width_adapter #(.LANES(LANES), .OUT_W(OUT_W), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk_in_clk                    (clk),
    .reset_in_rst                  (rst),
    .data_rx                       (data_rx),
    .valid_rx                      (valid_rx),
    .start_of_burst_rx             (sop_rx),
    .end_of_burst_rx               (eop_rx),
    .error_rx                      (error_rx),
    .sync_rx                       (sync_rx),
    .ready_rx                      (ready_rx),
    .avalonst_source_data          (src_data),
    .avalonst_source_valid         (src_valid),
    .avalonst_source_startofpacket (src_sop),
    .avalonst_source_endofpacket   (src_eop),
    .avalonst_source_error         (src_err),
    .avalonst_source_ready         (src_ready),
    .err_flags                     (err_flags),
    .err_count                     (err_count)
  );

  swm_rx_width_adapter #(.LANES(2), .OUT_W(64), .FIFO_DEPTH(2)) u_dut_wide (
    .clk_in_clk                    (clk),
    .reset_in_rst                  (rst),
    .data_rx                       (b_data),
    .valid_rx                      (b_valid),
    .start_of_burst_rx             (b_sop),
    .end_of_burst_rx               (b_eop),
    .error_rx                      (6'h00),
    .sync_rx                       (8'h00),
    .ready_rx                      (b_ready),
    .avalonst_source_data          (b_out_data),
    .avalonst_source_valid         (b_out_valid),
    .avalonst_source_startofpacket (b_out_sop),
    .avalonst_source_endofpacket   (b_out_eop),
    .avalonst_source_error         (b_out_err),
    .avalonst_source_ready         (1'b1),
    .err_flags                     (b_flags),
    .err_count                     (b_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat and hold it until accepted (bounded).
  task automatic send_beat(input logic [63:0] d, input logic s, input logic e, input logic [5:0] er);
    int   waited = 0;
    logic acc    = 1'b0;
    data_rx  = d;
    sop_rx   = s;
    eop_rx   = e;
    error_rx = er;
    valid_rx = 1'b1;
    do begin
      @(negedge clk);
      acc = ready_rx;
      tick();
      waited++;
    end while (!acc && waited < 200);
    if (!acc) check("send_timeout", 64'(acc), 64'(1));
    valid_rx = 1'b0;
    error_rx = '0;
  endtask

  // Reference model: each accepted beat expands into WORDS expected words.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      m_acc   = 1'b0;
      m_flags = '0;
      m_count = '0;
    end else begin
      if (src_valid && src_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", 64'(src_valid), 64'(0));
        end else begin
          word_t e;
          e = exp_q.pop_front();
          check("word_data", 64'(src_data), 64'(e.data));
          check("word_ctl", 64'({src_sop, src_eop, src_err}), 64'({e.sop, e.eop, e.err}));
        end
        if (src_eop) last_eop_err = src_err;
      end
      if (valid_rx && ready_rx) begin
        logic pe;
        pe = m_acc || (error_rx != 0);
        for (int w = 0; w < int'(WORDS); w++) begin
          word_t nw;
          nw.data = data_rx[w*OUT_W +: OUT_W];
          nw.sop  = sop_rx && (w == 0);
          nw.eop  = eop_rx && (w == int'(WORDS) - 1);
          nw.err  = nw.eop && pe;
          exp_q.push_back(nw);
        end
        m_acc   = eop_rx ? 1'b0 : pe;
        m_flags = m_flags | error_rx;
        if (error_rx != 0 && m_count != 16'hFFFF) m_count = m_count + 16'd1;
      end
    end
  end

  initial begin
    logic [63:0]  beats [4];
    logic [63:0]  d;
    logic [127:0] wide;
    valid_rx = 0; data_rx = '0; sop_rx = 0; eop_rx = 0; error_rx = '0; sync_rx = 8'h5A;
    src_ready = 0; b_valid = 0; b_data = '0; b_sop = 0; b_eop = 0;

    // Reset state
    repeat (3) tick();
    check("rst_ready", 64'(ready_rx), 64'(0));
    check("rst_valid", 64'(src_valid), 64'(0));
    check("rst_ctl", 64'({src_sop, src_eop, src_err}), 64'(0));
    check("rst_flags", 64'(err_flags), 64'(0));
    check("rst_count", 64'(err_count), 64'(0));
    rst = 1'b0;
    check("ready_pre_edge", 64'(ready_rx), 64'(0));
    tick();
    check("ready_post_edge", 64'(ready_rx), 64'(1));

    // Single beat, two words, no bubbles
    src_ready = 1'b1;
    send_beat(64'hAAAA_BBBB_CCCC_DDDD, 1'b1, 1'b1, 6'h00);
    check("w0_valid", 64'(src_valid), 64'(1));
    check("w0_data", 64'(src_data), 64'h0000_0000_CCCC_DDDD);
    check("w0_ctl", 64'({src_sop, src_eop, src_err}), 64'(3'b100));
    tick();
    check("w1_valid", 64'(src_valid), 64'(1));
    check("w1_data", 64'(src_data), 64'h0000_0000_AAAA_BBBB);
    check("w1_ctl", 64'({src_sop, src_eop, src_err}), 64'(3'b010));
    tick();
    check("w2_idle", 64'(src_valid), 64'(0));

    // Backpressure: fill, fifth beat refused, then drain in order
    src_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      beats[i] = {$urandom, $urandom};
      send_beat(beats[i], i == 0, i == 3, 6'h00);
    end
    data_rx  = {$urandom, $urandom};
    valid_rx = 1'b1;
    repeat (3) tick();
    check("full_ready", 64'(ready_rx), 64'(0));
    check("hold_valid", 64'(src_valid), 64'(1));
    d = beats[0];
    check("hold_data", 64'(src_data), 64'(d[31:0]));
    valid_rx  = 1'b0;
    src_ready = 1'b1;
    repeat (8) tick();
    check("drain_idle", 64'(src_valid), 64'(0));
    check("drain_ready", 64'(ready_rx), 64'(1));
    check("drain_q", 64'(exp_q.size()), 64'(0));

    // Error in middle beat flags only that packet's EOP word
    send_beat({$urandom, $urandom}, 1'b1, 1'b0, 6'h00);
    send_beat({$urandom, $urandom}, 1'b0, 1'b0, 6'h04);
    send_beat({$urandom, $urandom}, 1'b0, 1'b1, 6'h00);
    repeat (6) tick();
    check("pkt_err_eop", 64'(last_eop_err), 64'(1));
    check("err_flags", 64'(err_flags), 64'h04);
    check("err_count", 64'(err_count), 64'(1));
    send_beat({$urandom, $urandom}, 1'b1, 1'b1, 6'h00);
    repeat (3) tick();
    check("clean_pkt_err", 64'(last_eop_err), 64'(0));
    check("err_count_hold", 64'(err_count), 64'(1));

    // Two-lane, 64-bit output instance
    wide = {$urandom, $urandom, $urandom, $urandom};
    check("wide_ready", 64'(b_ready), 64'(1));
    b_data = wide; b_sop = 1'b1; b_eop = 1'b1; b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    check("wide_w0_valid", 64'(b_out_valid), 64'(1));
    check("wide_w0_data", b_out_data, wide[63:0]);
    check("wide_w0_ctl", 64'({b_out_sop, b_out_eop, b_out_err}), 64'(3'b100));
    tick();
    check("wide_w1_data", b_out_data, wide[127:64]);
    check("wide_w1_ctl", 64'({b_out_sop, b_out_eop, b_out_err}), 64'(3'b010));
    tick();
    check("wide_idle", 64'({b_out_valid, b_flags, b_count}), 64'(0));

    // Reset mid-beat discards remaining word without a partial EOP
    src_ready = 1'b0;
    send_beat({$urandom, $urandom}, 1'b1, 1'b1, 6'h01);
    src_ready = 1'b1;
    tick();
    check("mid_pending_eop", 64'({src_valid, src_eop}), 64'(2'b11));
    rst = 1'b1;
    #1;
    check("mid_rst_out", 64'({src_valid, src_eop, src_err}), 64'(0));
    repeat (2) tick();
    check("mid_rst_ready", 64'(ready_rx), 64'(0));
    check("mid_rst_err", 64'({err_flags, err_count}), 64'(0));
    rst = 1'b0;
    tick();
    check("post_rst_empty", 64'(src_valid), 64'(0));
    check("post_rst_ready", 64'(ready_rx), 64'(1));
    d = {$urandom, $urandom};
    send_beat(d, 1'b1, 1'b0, 6'h00);
    check("post_rst_sop", 64'({src_valid, src_sop}), 64'(2'b11));
    check("post_rst_data", 64'(src_data), 64'(d[31:0]));
    send_beat({$urandom, $urandom}, 1'b0, 1'b1, 6'h00);
    repeat (5) tick();

    // Random valid/ready stream
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 2)) tick();
          send_beat({$urandom, $urandom}, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'h00);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          tick();
          src_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    src_ready = 1'b1;
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) tick();
    tick();
    check("rand_drain_q", 64'(exp_q.size()), 64'(0));
    check("rand_idle", 64'(src_valid), 64'(0));
    check("rand_flags", 64'(err_flags), 64'(m_flags));
    check("rand_count", 64'(err_count), 64'(m_count));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
